// File: rtl/pwm_ramp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl_pkg
// Description : Shared definitions for the PWM duty ramp controller and the
//               PWM generator it feeds: default duty width, period/limit,
//               ramp step, reset duty, and the controller FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_ramp_ctrl_pkg;

    // Defaults shared with the PWM generator duty input
    localparam int c_DUTY_W    = 21;
    localparam int c_MAX_DUTY  = 1000000;
    localparam int c_STEP      = 1000;
    localparam int c_INIT_DUTY = 500000;

    // Width of the ramp rate (clk cycles per step)
    localparam int c_RATE_W    = 16;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RAMP = 2'd2,
        ST_DONE = 2'd3
    } ramp_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ramp_tick_gen
// Description : Ramp step timer. Counts clk cycles and raises tick when the
//               count reaches rate-1, then restarts from 0, so consecutive
//               ticks are rate cycles apart. clr holds the count at 0 and
//               suppresses tick.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               clr  - hold counter at zero (no tick)
//               rate - cycles per tick (caller guarantees rate >= 1)
//               tick - one-cycle step strobe (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module ramp_tick_gen
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int RATE_W = c_RATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    logic [RATE_W-1:0] r_cnt;
    logic [RATE_W-1:0] w_last;

    assign w_last = rate - RATE_W'(1);
    assign tick   = ~clr & (r_cnt == w_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + RATE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl
// Description : Ramps a PWM duty word toward a commanded target in fixed
//               STEP increments, one step every cmd_rate clk cycles.
//               After reset the INIT state loads INIT_DUTY into the PWM
//               generator once; then commands are accepted in IDLE.
// Ports       : clk, rst              - clock, async active-high reset
//               cmd_valid/cmd_ready   - command handshake (ready only in IDLE)
//               cmd_target            - final duty (clamped to MAX_DUTY)
//               cmd_rate              - clk cycles per step (0 acts as 1)
//               abort                 - cancel ramp in progress
//               duty_val / val_en     - registered duty and its load strobe
//               busy                  - ramp in progress
//               done                  - one-cycle ramp completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int DUTY_W    = c_DUTY_W,
    parameter int MAX_DUTY  = c_MAX_DUTY,
    parameter int STEP      = c_STEP,
    parameter int INIT_DUTY = c_INIT_DUTY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [15:0]       cmd_rate,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_val,
    output logic              val_en,
    output logic              busy,
    output logic              done
);

    localparam logic [DUTY_W-1:0] c_max_duty  = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] c_init_duty = DUTY_W'(INIT_DUTY);
    localparam logic [DUTY_W-1:0] c_step      = DUTY_W'(STEP);
    localparam logic [DUTY_W:0]   c_step_ext  = (DUTY_W+1)'(STEP);

    ramp_state_t       r_state;
    ramp_state_t       w_state_nxt;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] w_target_nxt;
    logic [15:0]       r_rate;
    logic [15:0]       w_rate_nxt;
    logic              r_val_en;
    logic              w_val_en_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic [DUTY_W-1:0] w_cmd_clamped;
    logic [15:0]       w_cmd_rate;
    logic [DUTY_W:0]   w_diff;
    logic [DUTY_W:0]   w_dist;
    logic              w_up;
    logic              w_near;
    logic              w_tick;
    logic              w_tick_clr;

    // ------------------------------------------------------------------
    // Command conditioning
    // ------------------------------------------------------------------
    assign w_cmd_clamped = (cmd_target > c_max_duty) ? c_max_duty : cmd_target;
    assign w_cmd_rate    = (cmd_rate == 16'd0) ? 16'd1 : cmd_rate;

    // ------------------------------------------------------------------
    // Distance to target: one extra bit so the sign of target-duty is
    // explicit and the magnitude never wraps.
    // ------------------------------------------------------------------
    assign w_diff = {1'b0, r_target} - {1'b0, r_duty};
    assign w_up   = ~w_diff[DUTY_W];
    assign w_dist = w_up ? w_diff : -w_diff;
    assign w_near = (w_dist <= c_step_ext);

    // ------------------------------------------------------------------
    // Step timer: held clear outside RAMP, so it always starts from 0 on
    // entry and the first tick lands rate cycles after acceptance.
    // ------------------------------------------------------------------
    assign w_tick_clr = (r_state != ST_RAMP);

    ramp_tick_gen #(
        .RATE_W (16)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tick_clr),
        .rate (r_rate),
        .tick (w_tick)
    );

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_duty   <= c_init_duty;
            r_target <= c_init_duty;
            r_rate   <= 16'd1;
            r_val_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_duty   <= w_duty_nxt;
            r_target <= w_target_nxt;
            r_rate   <= w_rate_nxt;
            r_val_en <= w_val_en_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic. val_en and done are registered, so
    // each strobe appears together with the value it qualifies.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_duty_nxt   = r_duty;
        w_target_nxt = r_target;
        w_rate_nxt   = r_rate;
        w_val_en_nxt = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_duty_nxt   = c_init_duty;
                w_val_en_nxt = 1'b1;
                w_state_nxt  = ST_IDLE;
            end

            ST_IDLE: begin
                if (cmd_valid) begin
                    w_target_nxt = w_cmd_clamped;
                    w_rate_nxt   = w_cmd_rate;
                    // Already at target: complete without touching the PWM
                    if (w_cmd_clamped == r_duty) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RAMP;
                    end
                end
            end

            ST_RAMP: begin
                // abort takes priority over a coincident tick
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    w_val_en_nxt = 1'b1;
                    if (w_near) begin
                        w_duty_nxt  = r_target;
                        w_state_nxt = ST_DONE;
                    end else if (w_up) begin
                        w_duty_nxt = r_duty + c_step;
                    end else begin
                        w_duty_nxt = r_duty - c_step;
                    end
                end
            end

            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign duty_val  = r_duty;
    assign val_en    = r_val_en;
    assign done      = r_done;
    assign busy      = (r_state == ST_RAMP);
    assign cmd_ready = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_ramp_ctrl
// Description : Directed self-checking bench for pwm_ramp_ctrl with default
//               parameters. Inputs change on the falling edge; outputs are
//               sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [20:0] cmd_target;
    logic [15:0] cmd_rate;
    logic        abort;
    logic [20:0] duty_val;
    logic        val_en;
    logic        busy;
    logic        done;

    int n_checks;
    int n_errors;

    pwm_ramp_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_rate   (cmd_rate),
        .abort      (abort),
        .duty_val   (duty_val),
        .val_en     (val_en),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers (no checking). Called at a falling edge; return at
    // the falling edge right after the accepting rising edge.
    task automatic send_cmd(input logic [20:0] tgt, input logic [15:0] rate);
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_rate   = rate;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (duty_val !== 21'd500000) begin n_errors++; $display("FAIL reset duty_val got %0d exp 500000", duty_val); end
        n_checks++; if ({val_en, cmd_ready, busy, done} !== 4'b0000) begin n_errors++; $display("FAIL reset flags {val_en,ready,busy,done} got %b exp 0000", {val_en, cmd_ready, busy, done}); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (val_en !== 1'b1 || duty_val !== 21'd500000) begin n_errors++; $display("FAIL init_pulse val_en=%b duty=%0d exp 1/500000", val_en, duty_val); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL init_ready got %b exp 1", cmd_ready); end
        @(negedge clk);
        n_checks++; if (val_en !== 1'b0) begin n_errors++; $display("FAIL init_single_pulse val_en got %b exp 0", val_en); end
    endtask

    task automatic test_ramp_up();
        int exp_d;
        logic exp_v;
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL ramp_up ready got %b exp 1", cmd_ready); end
        send_cmd(21'd503500, 16'd4);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL ramp_up busy got %b exp 1", busy); end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_v = ((k % 4) == 0);
            exp_d = 500000 + (k / 4) * 1000;
            if (k == 16) exp_d = 503500;
            n_checks++; if (val_en !== exp_v) begin n_errors++; $display("FAIL ramp_up val_en k=%0d got %b exp %b", k, val_en, exp_v); end
            n_checks++; if (duty_val !== 21'(exp_d)) begin n_errors++; $display("FAIL ramp_up duty k=%0d got %0d exp %0d", k, duty_val, exp_d); end
            n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL ramp_up early_done k=%0d got %b exp 0", k, done); end
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || val_en !== 1'b0) begin n_errors++; $display("FAIL ramp_up done done=%b val_en=%b exp 1/0", done, val_en); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL ramp_up after done=%b ready=%b exp 0/1", done, cmd_ready); end
    endtask

    task automatic test_ramp_down_rate0();
        apply_reset();
        send_cmd(21'd498000, 16'd0);
        @(negedge clk);
        n_checks++; if (val_en !== 1'b1 || duty_val !== 21'd499000) begin n_errors++; $display("FAIL rate0 step1 val_en=%b duty=%0d exp 1/499000", val_en, duty_val); end
        @(negedge clk);
        n_checks++; if (val_en !== 1'b1 || duty_val !== 21'd498000) begin n_errors++; $display("FAIL rate0 step2 val_en=%b duty=%0d exp 1/498000", val_en, duty_val); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || val_en !== 1'b0) begin n_errors++; $display("FAIL rate0 done done=%b val_en=%b exp 1/0", done, val_en); end
        @(negedge clk);
    endtask

    task automatic test_clamp();
        int pulses;
        int max_d;
        logic seen_done;
        pulses = 0; max_d = 0; seen_done = 1'b0;
        send_cmd(21'd2000000, 16'd1);
        for (int c = 0; c < 700 && !seen_done; c++) begin
            @(negedge clk);
            if (val_en) pulses++;
            if (int'(duty_val) > max_d) max_d = int'(duty_val);
            if (done) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b1) begin n_errors++; $display("FAIL clamp timeout done got %b exp 1", seen_done); end
        n_checks++; if (duty_val !== 21'd1000000) begin n_errors++; $display("FAIL clamp final duty got %0d exp 1000000", duty_val); end
        n_checks++; if (max_d != 1000000) begin n_errors++; $display("FAIL clamp max duty got %0d exp 1000000", max_d); end
        n_checks++; if (pulses != 502) begin n_errors++; $display("FAIL clamp pulse count got %0d exp 502", pulses); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        apply_reset();
        send_cmd(21'd510000, 16'd3);
        repeat (3) @(negedge clk);
        n_checks++; if (val_en !== 1'b1 || duty_val !== 21'd501000) begin n_errors++; $display("FAIL abort first step val_en=%b duty=%0d exp 1/501000", val_en, duty_val); end
        repeat (2) @(negedge clk);
        abort = 1'b1;   // sampled on the edge that would also carry the 2nd tick
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (duty_val !== 21'd501000 || val_en !== 1'b0) begin n_errors++; $display("FAIL abort hold duty=%0d val_en=%b exp 501000/0", duty_val, val_en); end
        n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL abort idle ready=%b busy=%b exp 1/0", cmd_ready, busy); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (done !== 1'b0 || duty_val !== 21'd501000) begin n_errors++; $display("FAIL abort quiet c=%0d done=%b duty=%0d exp 0/501000", c, done, duty_val); end
        end
    endtask

    task automatic test_equal_target();
        apply_reset();
        abort = 1'b1;   // outside RAMP: must have no effect
        send_cmd(21'd500000, 16'd5);
        n_checks++; if (busy !== 1'b0 || val_en !== 1'b0) begin n_errors++; $display("FAIL equal busy=%b val_en=%b exp 0/0", busy, val_en); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || val_en !== 1'b0 || duty_val !== 21'd500000) begin n_errors++; $display("FAIL equal done=%b val_en=%b duty=%0d exp 1/0/500000", done, val_en, duty_val); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL equal after done=%b ready=%b exp 0/1", done, cmd_ready); end
        abort = 1'b0;
    endtask

    task automatic test_cmd_ignored();
        send_cmd(21'd501500, 16'd2);
        cmd_valid  = 1'b1;
        cmd_target = 21'd400000;
        cmd_rate   = 16'd1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL ignored ready=%b busy=%b exp 0/1", cmd_ready, busy); end
        @(negedge clk);
        n_checks++; if (val_en !== 1'b1 || duty_val !== 21'd501000) begin n_errors++; $display("FAIL ignored step1 val_en=%b duty=%0d exp 1/501000", val_en, duty_val); end
        repeat (2) @(negedge clk);
        n_checks++; if (val_en !== 1'b1 || duty_val !== 21'd501500) begin n_errors++; $display("FAIL ignored step2 val_en=%b duty=%0d exp 1/501500", val_en, duty_val); end
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL ignored done got %b exp 1", done); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (busy !== 1'b0 || val_en !== 1'b0 || duty_val !== 21'd501500) begin n_errors++; $display("FAIL ignored queued c=%0d busy=%b val_en=%b duty=%0d exp 0/0/501500", c, busy, val_en, duty_val); end
        end
    endtask

    task automatic test_back_to_back();
        send_cmd(21'd502500, 16'd1);
        @(negedge clk);
        n_checks++; if (val_en !== 1'b1 || duty_val !== 21'd502500) begin n_errors++; $display("FAIL b2b step val_en=%b duty=%0d exp 1/502500", val_en, duty_val); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL b2b done=%b ready=%b exp 1/1", done, cmd_ready); end
        send_cmd(21'd501500, 16'd1);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b second accept busy got %b exp 1", busy); end
        @(negedge clk);
        n_checks++; if (val_en !== 1'b1 || duty_val !== 21'd501500) begin n_errors++; $display("FAIL b2b second step val_en=%b duty=%0d exp 1/501500", val_en, duty_val); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL b2b second done got %b exp 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_ramp();
        int pulses;
        int bad;
        pulses = 0; bad = 0;
        send_cmd(21'd510000, 16'd2);
        repeat (4) @(negedge clk);
        n_checks++; if (duty_val !== 21'd503500) begin n_errors++; $display("FAIL midrst pre duty got %0d exp 503500", duty_val); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (duty_val !== 21'd500000) begin n_errors++; $display("FAIL midrst async duty got %0d exp 500000", duty_val); end
        n_checks++; if ({val_en, cmd_ready, busy, done} !== 4'b0000) begin n_errors++; $display("FAIL midrst async flags got %b exp 0000", {val_en, cmd_ready, busy, done}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (val_en !== 1'b1 || duty_val !== 21'd500000) begin n_errors++; $display("FAIL midrst init val_en=%b duty=%0d exp 1/500000", val_en, duty_val); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (val_en) pulses++;
            if (busy || duty_val !== 21'd500000) bad++;
        end
        n_checks++; if (pulses != 0) begin n_errors++; $display("FAIL midrst extra val_en got %0d exp 0", pulses); end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL midrst resumed cycles got %0d exp 0", bad); end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_rate   = '0;
        abort      = 1'b0;

        test_reset();
        test_ramp_up();
        test_ramp_down_rate0();
        test_clamp();
        test_abort();
        test_equal_target();
        test_cmd_ignored();
        test_back_to_back();
        test_reset_mid_ramp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter DUTY_W, default 21, SHALL set the duty word width, matching the PWM generator duty input.
REQ-002 Parameter MAX_DUTY, default 1000000, SHALL set the PWM period count and the upper duty limit.
REQ-003 Parameter STEP, default 1000, SHALL set the duty increment applied per ramp tick.
REQ-004 Parameter INIT_DUTY, default 500000, SHALL set the duty loaded at reset.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 cmd_valid  in  1  ramp command offered.
REQ-008 cmd_ready  out  1  controller accepts a command this cycle.
REQ-009 cmd_target  in  DUTY_W  requested final duty.
REQ-010 cmd_rate  in  16  clk cycles per ramp step.
REQ-011 abort  in  1  cancel the ramp in progress.
REQ-012 duty_val  out  DUTY_W  current duty, registered, drives the PWM generator duty input.
REQ-013 val_en  out  1  one-cycle load strobe for duty_val.
REQ-014 busy  out  1  high in RAMP state.
REQ-015 done  out  1  one-cycle pulse when a ramp completes.

Function
REQ-016 The FSM SHALL have states INIT, IDLE, RAMP and DONE.
REQ-017 INIT SHALL assert val_en for exactly one cycle with duty_val=INIT_DUTY, then go to IDLE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-019 On accept, the target SHALL be latched clamped to MAX_DUTY, and the rate latched with 0 treated as 1.
REQ-020 On accept with clamped target equal to duty_val, the FSM SHALL go to DONE without any val_en.
REQ-021 Otherwise on accept, the FSM SHALL go to RAMP with the tick counter cleared.
REQ-022 In RAMP, a tick SHALL occur when the tick counter reaches rate-1; the counter then resets to 0, so the first tick is rate cycles after accept.
REQ-023 On a tick with |target-duty_val| > STEP, duty_val SHALL move by STEP toward target and val_en SHALL pulse in the same cycle as the duty_val update.
REQ-024 On a tick with |target-duty_val| <= STEP, duty_val SHALL equal target, val_en SHALL pulse, and the FSM SHALL go to DONE.
REQ-025 Difference arithmetic SHALL use DUTY_W+1 bits; duty_val SHALL never leave the range 0..MAX_DUTY.
REQ-026 DONE SHALL assert done for one cycle, then return to IDLE; a command can be accepted on the following cycle.
REQ-027 abort in RAMP SHALL move the FSM to IDLE next cycle, with duty_val holding its last value, no val_en and no done.
REQ-028 If abort and a tick coincide, abort SHALL win: no update occurs.
REQ-029 abort outside RAMP SHALL be ignored.
REQ-030 cmd_valid outside IDLE SHALL be ignored and not queued.

Reset
REQ-031 While rst=1, the FSM SHALL be in INIT with duty_val=INIT_DUTY, val_en=0, cmd_ready=0, busy=0, done=0, and the tick counter at 0.
REQ-032 rst asserted mid-ramp SHALL discard the command; after release, exactly one INIT val_en pulse SHALL occur.

Structure
REQ-033 The shared package SHALL hold the FSM state enum and the defaults for MAX_DUTY, STEP, INIT_DUTY and DUTY_W, common with the PWM generator.
REQ-034 The tick counter SHALL be one sub-module, ramp_tick_gen, with inputs clk, rst, clr and rate and output tick.

Verification
REQ-035 Release reset -> one val_en with duty_val=500000 one cycle after release, then cmd_ready=1.
REQ-036 Command target=503500, rate=4 -> val_en at +4, +8, +12, +16 cycles after accept with values 501000, 502000, 503000, 503500; done one cycle after the last update.
REQ-037 Command target=498000, rate=0 -> updates on consecutive cycles: 499000, then 498000; done follows.
REQ-038 Command target=2000000 -> ramp ends at 1000000; duty_val never exceeds 1000000.
REQ-039 Abort two cycles after the first update of a ramp to 510000 -> duty_val stays 501000, no done, cmd_ready=1 next cycle; command target=500000 while duty_val=500000 -> done with no val_en.
REQ-040 rst asserted mid-ramp -> outputs return to reset values immediately; after release, the INIT pulse with 500000 appears and the old target is never reached.
